// File: rtl/mem_responder.sv
// Multi-port memory responder: round-robin arbitration across NCORES initiators, 3-cycle transactions.
// Optional completed-transaction counter enabled by defining MEM_RESPONDER_STATS_EN.
module mem_responder #(
  parameter int NCORES = 4,
  parameter int AW     = 11,
  parameter int DW     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCORES-1:0]    req,
  input  logic [NCORES-1:0]    we,
  input  logic [NCORES*AW-1:0] addr,
  input  logic [NCORES*DW-1:0] wdata,
  output logic [NCORES-1:0]    gnt,
  output logic [NCORES-1:0]    rvalid,
  output logic [NCORES*DW-1:0] rdata,
  output logic                 busy,
  output logic [15:0]          txn_count
);

  // state  | meaning
  // IDLE   | waiting for any req; capture winner on the next edge
  // ACCESS | perform the captured write or read of mem
  // RESP   | gnt (and rvalid for reads) visible for one cycle
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, win, w_q;
  logic            found;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [NCORES-1:0] gnt_nxt, rvalid_nxt;
  logic [DW-1:0]   mem [2**AW];

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int k);
    return PW'((int'(p) + k) % NCORES);
  endfunction

  // First requester at or after ptr, wrapping.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < NCORES; k++) begin
      if (!found && req[rr_idx(ptr, k)]) begin
        found = 1'b1;
        win   = rr_idx(ptr, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt    = '0;
    rvalid_nxt = '0;
    if (state == ACCESS) begin
      gnt_nxt[w_q]    = 1'b1;
      rvalid_nxt[w_q] = !we_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && found) begin
      w_q     <= win;
      we_q    <= we[win];
      addr_q  <= addr[win*AW +: AW];
      wdata_q <= wdata[win*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (state == ACCESS && we_q) mem[addr_q] <= wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt    <= '0;
      rvalid <= '0;
      rdata  <= '0;
      busy   <= 1'b0;
      ptr    <= '0;
    end else begin
      gnt    <= gnt_nxt;
      rvalid <= rvalid_nxt;
      busy   <= (state_nxt != IDLE);
      if (state == ACCESS && !we_q) rdata[w_q*DW +: DW] <= mem[addr_q];
      if (state == RESP) ptr <= (w_q == PW'(NCORES - 1)) ? '0 : w_q + 1'b1;
    end
  end

`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                cnt <= '0;
    else if (state == RESP && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end

  assign txn_count = cnt;
`else
  assign txn_count = '0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: arbitration order, read/write data, reset abandonment, stats counter.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, we;
  logic [43:0] addr;
  logic [31:0] wdata;
  logic [3:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic        busy;
  logic [15:0] txn_count;

  int n_checks = 0;
  int fails    = 0;

  mem_responder #(.NCORES(4), .AW(11), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for any gnt, bounded; returns the grant vector and edges waited.
  task automatic wait_gnt(output logic [3:0] g, output int cyc);
    g   = '0;
    cyc = 0;
    while (g == 4'd0 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      g = gnt;
    end
    n_checks++;
    assert (g !== 4'd0) else begin
      fails++;
      $error("FAIL gnt_timeout observed=%0h expected=nonzero", g);
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_txn_count", txn_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Single transaction from an idle cycle; returns in the following idle cycle.
  task automatic txn(input int c, input logic w, input logic [10:0] a, input logic [7:0] d,
                     input logic [7:0] exp_rd);
    req[c] = 1'b1;
    we[c]  = w;
    addr[c*11 +: 11] = a;
    wdata[c*8 +: 8]  = d;
    @(posedge clk); #1;
    chk("cap_busy", busy, 1);
    chk("cap_gnt_early", gnt, 0);
    addr[c*11 +: 11] = ~a;
    wdata[c*8 +: 8]  = ~d;
    we[c] = ~w;
    @(posedge clk); #1;
    chk("resp_gnt", gnt, 32'd1 << c);
    chk("resp_rvalid", rvalid, w ? 32'd0 : (32'd1 << c));
    if (!w) chk("resp_rdata", rdata[c*8 +: 8], exp_rd);
    req[c] = 1'b0;
    @(posedge clk); #1;
    chk("idle_gnt", gnt, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    logic [3:0] g;
    int cyc;
    logic [3:0] exp_g;

    req = '0; we = '0; addr = '0; wdata = '0; rst_n = 1'b0;
    #2;
    reset_pulse();

    // Single core write then read-back.
    txn(0, 1'b1, 11'h040, 8'hA0, 8'h00);
    txn(0, 1'b0, 11'h040, 8'h00, 8'hA0);

    // All four cores contend for writes, then for reads.
    reset_pulse();
    req = 4'hF; we = 4'hF;
    for (int i = 0; i < 4; i++) begin
      addr[i*11 +: 11] = 11'h040 + 11'(i);
      wdata[i*8 +: 8]  = 8'hA0 + 8'(i);
    end
    for (int i = 0; i < 4; i++) begin
      wait_gnt(g, cyc);
      chk("wr_order", g, 32'd1 << i);
      chk("wr_rvalid", rvalid, 0);
      req[i] = 1'b0;
    end
    @(posedge clk); #1;
    req = 4'hF; we = 4'h0;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(g, cyc);
      chk("rd_order", g, 32'd1 << i);
      chk("rd_rvalid", rvalid, 32'd1 << i);
      chk("rd_data", rdata[i*8 +: 8], 8'hA0 + 8'(i));
      req[i] = 1'b0;
    end
    chk("rd_data_hold", rdata, 32'hA3A2A1A0);
    @(posedge clk); #1;

    // Cores 1 and 3 hold req continuously.
    req = 4'b1010; we = 4'b0000;
    addr[1*11 +: 11] = 11'h041;
    addr[3*11 +: 11] = 11'h043;
    for (int j = 0; j < 6; j++) begin
      exp_g = (j % 2 == 1) ? 4'b1000 : 4'b0010;
      wait_gnt(g, cyc);
      chk("rr_order", g, exp_g);
      if (j > 0) chk("rr_spacing", cyc, 3);
      if (j == 5) req = '0;
    end
    chk("rr_rdata", rdata, 32'hA3A2A1A0);
    @(posedge clk); #1;

    // Cross-core read-after-write.
    txn(0, 1'b1, 11'h100, 8'h5A, 8'h00);
    txn(2, 1'b0, 11'h100, 8'h00, 8'h5A);

    // Reset while a read response is being presented.
    req[2] = 1'b1; we[2] = 1'b0; addr[2*11 +: 11] = 11'h100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_gnt", gnt, 4'b0100);
    chk("pre_rst_rvalid", rvalid, 4'b0100);
    rst_n = 1'b0;
    req = '0;
    #1;
    chk("midrst_gnt", gnt, 0);
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rdata", rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req = 4'b1010; we = 4'b0000;
    addr[1*11 +: 11] = 11'h041;
    addr[3*11 +: 11] = 11'h043;
    wait_gnt(g, cyc);
    chk("post_rst_winner", g, 4'b0010);
    chk("post_rst_rdata", rdata[15:8], 8'hA1);
    chk("post_rst_latency", cyc, 2);
    req = '0;
    @(posedge clk); #1;

    // Eight transactions from a fresh reset.
    reset_pulse();
    for (int i = 0; i < 8; i++) txn(i % 4, 1'b1, 11'h080 + 11'(i), 8'(i), 8'h00);
`ifdef MEM_RESPONDER_STATS_EN
    chk("txn_count", txn_count, 8);
`else
    chk("txn_count", txn_count, 0);
`endif
    txn(1, 1'b0, 11'h085, 8'h00, 8'h05);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter NCORES, default 4, meaning number of initiator ports.
REQ-002 The block SHALL have parameter AW, default 11, meaning address width (2048-byte memory, depth 2**AW).
REQ-003 The block SHALL have parameter DW, default 8, meaning data width.
REQ-004 The block SHALL have these ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  NCORES  per-core request.
- we  input  NCORES  per-core write enable (1=write, 0=read).
- addr  input  NCORES*AW  per-core address, core i at slice [i*AW +: AW].
- wdata  input  NCORES*DW  per-core write data, slice [i*DW +: DW].
- gnt  output  NCORES  per-core grant, one-hot or zero.
- rvalid  output  NCORES  per-core read-data valid.
- rdata  output  NCORES*DW  per-core read data, slice [i*DW +: DW].
- busy  output  1  transaction in progress (state != IDLE).
- txn_count  output  16  completed-transaction counter (see Configuration).

Function
REQ-005 The block SHALL hold a 2**AW x DW memory array, single access per transaction, no reset of contents.
REQ-006 The FSM SHALL have states IDLE, ACCESS, RESP; all outputs SHALL be registered.
REQ-007 IDLE: if any req bit is high, the block SHALL select winner w by round-robin starting at pointer ptr, latch we[w], addr[w], wdata[w], and go to ACCESS; otherwise stay in IDLE.
REQ-008 ACCESS: for a write, the block SHALL write wdata to mem[addr]; for a read, it SHALL register mem[addr]; it SHALL then go to RESP.
REQ-009 RESP: the block SHALL assert gnt[w] for exactly one cycle; for a read, it SHALL also assert rvalid[w] in the same cycle with rdata slice w = read value.
REQ-010 RESP SHALL always go to IDLE, and ptr SHALL become (w+1) mod NCORES on leaving RESP.
REQ-011 gnt SHALL first assert in the 3rd cycle after req is first sampled high (capture edge, ACCESS, RESP), never earlier.
REQ-012 rvalid SHALL assert only with gnt of the same core and only for reads; gnt and rvalid SHALL be zero for all other cores.
REQ-013 The rdata slice of core i SHALL update only on core i's read response and hold its value otherwise.
REQ-014 Requests arriving during ACCESS/RESP SHALL be ignored until the next IDLE cycle; a losing request SHALL NOT be dropped as long as its req stays high.
REQ-015 A read issued after a completed write to the same address SHALL return the written data, regardless of core.
REQ-016 Changes to we/addr/wdata after capture SHALL NOT affect the current transaction.
REQ-017 Throughput SHALL be one transaction per 3 cycles (IDLE, ACCESS, RESP) under continuous requests.

Reset
REQ-018 While rst_n is low, the block SHALL force state=IDLE, ptr=0, gnt=0, rvalid=0, rdata=0, busy=0, and txn_count=0, asynchronously.
REQ-019 On reset mid-transaction, the block SHALL abandon the transaction with no gnt and no rvalid; a write captured but not yet in ACCESS SHALL NOT be performed.

Configuration
REQ-020 With MEM_RESPONDER_STATS_EN defined, txn_count SHALL increment by 1 at each RESP cycle and saturate at 0xFFFF.
REQ-021 Without MEM_RESPONDER_STATS_EN, txn_count SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Single write: core0 writes 0x040=0xA0 then reads 0x040 -> gnt[0] in the 3rd cycle after req, then rvalid[0]=1 with rdata[0]=0xA0.
- All cores: after reset, cores 0-3 write 0x040+i=0xA0+i then read -> grant order 0,1,2,3 for writes, then for reads; rdata slice i=0xA0+i, no cross-core rvalid.
- Fairness: only cores 1 and 3 hold req continuously for 6 transactions -> grants alternate 1,3,1,3,1,3.
- Cross-core RAW: core0 writes 0x100=0x5A, then core2 reads 0x100 -> rdata[2]=0x5A.
- Reset in RESP: assert rst_n=0 during RESP -> gnt=0 and rvalid=0 immediately, ptr=0, next grant goes to the lowest requesting core.
- Stats: 8 transactions -> txn_count=8 with MEM_RESPONDER_STATS_EN; txn_count=0 without it.
